mult_div_unit: RTL

- Iterative multiply/divide sequencer for the MIPS core. Executes mult, multu, div and divu, and owns the HI/LO registers.
- The CPU issues an operation with a one-cycle start pulse and stalls on busy. mfhi/mflo read hi/lo directly; mthi/mtlo write through hi_we/lo_we.
- Sits beside the register file. Operands come from the RF read ports, and its outputs feed the writeback mux.

---
 rtl/mult_div_unit.sv | 121 ++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative shift-add multiplier / restoring divider owning HI/LO
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int CW = $clog2(WIDTH + 1);
   typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
   logic [2*WIDTH-1:0] acc_q, acc_d, prod;
   logic neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d, div_q, div_d, done_q, done_d;
   logic [WIDTH:0] sum, rem_sh, diff;
   logic [WIDTH-1:0] quo, rem;
   logic sa, sb;
   // next-state: operand capture, one multiply/divide step per cycle, sign fix-up and HI/LO writes
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      neg_d   = neg_q;
      rneg_d  = rneg_q;
      dz_d    = dz_q;
      div_d   = div_q;
      done_d  = 1'b0;
      sa      = ~op[0] & a[WIDTH-1];
      sb      = ~op[0] & b[WIDTH-1];
      sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, a_q & {WIDTH{b_q[0]}}};
      rem_sh  = {acc_q[WIDTH-1:0], a_q[WIDTH-1]};
      diff    = rem_sh - {1'b0, b_q};
      prod    = neg_q ? -acc_q : acc_q;
      quo     = neg_q ? -a_q : a_q;
      rem     = rneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      case (state_q)
         IDLE: begin
            hi_d = hi_we ? wdata : hi_q;
            lo_d = lo_we ? wdata : lo_q;
            if (start) begin
               a_d     = sa ? -a : a;
               b_d     = sb ? -b : b;
               acc_d   = '0;
               cnt_d   = CW'(WIDTH);
               neg_d   = sa ^ sb;
               rneg_d  = sa;
               dz_d    = (b == '0);
               div_d   = op[1];
               state_d = op[1] ? DIV : MUL;
            end
         end
         MUL: begin
            acc_d   = {sum, acc_q[WIDTH-1:1]};
            b_d     = b_q >> 1;
            cnt_d   = cnt_q - CW'(1);
            state_d = (cnt_q == CW'(1)) ? FIX : MUL;
         end
         DIV: begin
            acc_d   = {acc_q[2*WIDTH-1:WIDTH], diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0]};
            a_d     = {a_q[WIDTH-2:0], ~diff[WIDTH]};
            cnt_d   = cnt_q - CW'(1);
            state_d = (cnt_q == CW'(1)) ? FIX : DIV;
         end
         default: begin
            hi_d    = div_q ? rem : prod[2*WIDTH-1:WIDTH];
            lo_d    = div_q ? (dz_q ? '1 : quo) : prod[WIDTH-1:0];
            done_d  = 1'b1;
            state_d = IDLE;
         end
      endcase
   end
   // state register with synchronous reset discarding any in-flight operation
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
         dz_q    <= 1'b0;
         div_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         neg_q   <= neg_d;
         rneg_q  <= rneg_d;
         dz_q    <= dz_d;
         div_q   <= div_d;
         done_q  <= done_d;
      end
   end
   assign busy = (state_q != IDLE);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;
endmodule
